instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 57 +++++
 rtl/instr_fetch.sv | 90 +++++++++
 tb/tb_instr_fetch.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared widths, PC step and FIFO entry type for the fetch unit
// Rev 1.0
// ============================================================================
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] c_pc_inc = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// fetch_buffer : DEPTH-entry FIFO of {instr, pc} with synchronous flush
// Rev 1.0
// ============================================================================
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;

  logic             w_pop;
  logic             w_push;

  // Pop is ignored when empty; push at full is legal only alongside a pop.
  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != (AW+1)'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= push_data;
  end

  assign head  = r_mem[r_rd];
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : credit-based instruction fetch with redirect and FIFO buffer
// Rev 1.0
// ============================================================================
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [XLEN-1:0]     if_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  r_pc;
  logic             r_inflight;
  logic [XLEN-1:0]  r_inflight_pc;

  logic             w_req;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [CW:0]      w_used;
  fetch_entry_t     w_push_data;
  fetch_entry_t     w_head;
  logic             w_unused_lsbs;

  // Credits count buffered plus in-flight words, so a response always has a slot.
  assign w_used   = {1'b0, w_count} + (CW+1)'(r_inflight);
  assign w_req    = !rst && !redirect && (w_used < (CW+1)'(DEPTH));
  assign w_push   = r_inflight && !redirect;
  assign w_pop    = if_valid && if_ready;

  assign w_push_data.instr = imem_rdata;
  assign w_push_data.pc    = r_inflight_pc;

  assign w_unused_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect) begin
      r_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_pc          <= r_pc + c_pc_inc;
        r_inflight_pc <= r_pc;
      end
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign if_valid  = !w_empty && !rst;
  assign if_instr  = w_head.instr;
  assign if_pc     = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch : directed self-checking bench for instr_fetch
// Rev 1.0
// ============================================================================
module tb_instr_fetch;

  localparam logic [31:0] KEY     = 32'hA5A5_A5A5;
  localparam logic [31:0] RESET_W = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_req, redirect, if_valid, if_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, if_instr, if_pc;

  logic        imem_req_w, if_valid_w;
  logic [31:0] imem_addr_w, imem_rdata_w, if_instr_w, if_pc_w;
  logic        redirect_w = 1'b0;
  logic        if_ready_w = 1'b1;
  logic [31:0] redirect_pc_w = 32'h0;

  instr_fetch dut (
    .clk (clk), .rst (rst),
    .imem_req (imem_req), .imem_addr (imem_addr), .imem_rdata (imem_rdata),
    .redirect (redirect), .redirect_pc (redirect_pc),
    .if_valid (if_valid), .if_ready (if_ready),
    .if_instr (if_instr), .if_pc (if_pc)
  );

  instr_fetch #(.RESET_PC (RESET_W), .DEPTH (4)) dut_w (
    .clk (clk), .rst (rst),
    .imem_req (imem_req_w), .imem_addr (imem_addr_w), .imem_rdata (imem_rdata_w),
    .redirect (redirect_w), .redirect_pc (redirect_pc_w),
    .if_valid (if_valid_w), .if_ready (if_ready_w),
    .if_instr (if_instr_w), .if_pc (if_pc_w)
  );

  // Memory returns addr ^ KEY one cycle after the request.
  always_ff @(posedge clk) begin
    imem_rdata   <= imem_addr ^ KEY;
    imem_rdata_w <= imem_addr_w ^ KEY;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          nreq, unstable, nhs;

    rst = 1'b1; if_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    tick(); tick(); #1;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(if_valid), 32'd0);

    // Streaming from reset: request every cycle, delivery from cycle 2.
    rst = 1'b0; #1;
    check_eq("t1_req_c0", 32'(imem_req), 32'd1);
    check_eq("t1_addr_c0", imem_addr, 32'h0);
    for (int k = 1; k < 8; k++) begin
      tick(); #1;
      check_eq("t1_addr", imem_addr, 32'(4 * k));
      check_eq("t1_valid", 32'(if_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        check_eq("t1_pc", if_pc, 32'(4 * (k - 2)));
        check_eq("t1_instr", if_instr, 32'(4 * (k - 2)) ^ KEY);
      end
      if (k >= 2 && k <= 4) begin
        exp_pc = RESET_W + 32'(4 * (k - 2));
        check_eq("wrap_pc", if_pc_w, exp_pc);
      end
    end

    // Stall for 10 cycles from reset, then release.
    rst = 1'b1; tick(); rst = 1'b0; if_ready = 1'b0;
    nreq = 0; unstable = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      #1;
      nreq += int'(imem_req);
      if (c >= 2 && (!if_valid || if_pc != 32'h0)) unstable++;
    end
    check_eq("stall_nreq", 32'(nreq), 32'd4);
    check_eq("stall_unstable", 32'(unstable), 32'd0);
    for (int c = 10; c < 15; c++) begin
      tick(); if_ready = 1'b1; #1;
      check_eq("rel_valid", 32'(if_valid), 32'd1);
      check_eq("rel_pc", if_pc, 32'(4 * (c - 10)));
      if (c == 10) check_eq("rel_req_c10", 32'(imem_req), 32'd0);
      if (c == 11) check_eq("rel_addr_c11", imem_addr, 32'd16);
    end

    // Reset pulse while three entries are buffered.
    rst = 1'b1; tick(); rst = 1'b0; if_ready = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    #1;
    check_eq("pulse_pre_valid", 32'(if_valid), 32'd1);
    rst = 1'b1; #1;
    check_eq("pulse_rst_req", 32'(imem_req), 32'd0);
    check_eq("pulse_rst_valid", 32'(if_valid), 32'd0);
    tick(); rst = 1'b0; if_ready = 1'b1; #1;
    check_eq("pulse_valid", 32'(if_valid), 32'd0);
    check_eq("pulse_addr", imem_addr, 32'h0);
    tick(); #1;
    check_eq("pulse_valid2", 32'(if_valid), 32'd0);
    tick(); #1;
    check_eq("pulse_pc", if_pc, 32'h0);

    // Redirect mid-stream, then back-to-back redirects.
    rst = 1'b1; tick(); rst = 1'b0; if_ready = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0102; #1;
    check_eq("rd_req_R", 32'(imem_req), 32'd0);
    check_eq("rd_pc_R", if_pc, 32'd12);
    tick(); redirect = 1'b0; #1;
    check_eq("rd_addr_R1", imem_addr, 32'h100);
    check_eq("rd_req_R1", 32'(imem_req), 32'd1);
    check_eq("rd_valid_R1", 32'(if_valid), 32'd0);
    tick(); #1;
    check_eq("rd_valid_R2", 32'(if_valid), 32'd0);
    check_eq("rd_addr_R2", imem_addr, 32'h104);
    tick(); #1;
    check_eq("rd_pc_R3", if_pc, 32'h100);
    check_eq("rd_instr_R3", if_instr, 32'h100 ^ KEY);
    tick();
    redirect = 1'b1; redirect_pc = 32'h200; #1;
    check_eq("rd_pc_R4", if_pc, 32'h104);
    tick(); redirect_pc = 32'h300; #1;
    check_eq("b2b_req", 32'(imem_req), 32'd0);
    tick(); redirect = 1'b0; #1;
    check_eq("b2b_addr", imem_addr, 32'h300);
    check_eq("b2b_valid1", 32'(if_valid), 32'd0);
    tick(); #1;
    check_eq("b2b_valid2", 32'(if_valid), 32'd0);
    tick(); #1;
    check_eq("b2b_pc", if_pc, 32'h300);

    // Random ready/redirect against a sequential-PC expectation.
    rst = 1'b1; tick(); rst = 1'b0;
    exp_pc = 32'h0; nhs = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if_ready    = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      #1;
      if (if_valid && if_ready) begin
        check_eq("rnd_pc", if_pc, exp_pc);
        check_eq("rnd_instr", if_instr, exp_pc ^ KEY);
        exp_pc = exp_pc + 32'd4;
        nhs++;
      end
      if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
    end
    redirect = 1'b0;
    check_eq("rnd_progress", 32'(nhs > 60), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
